output_port_arbiter: RTL and testbench



---
 rtl/noc_router_pkg.sv | 36 +++
 rtl/output_port_arbiter_if.sv | 37 +++
 rtl/output_port_arbiter_rr_priority_picker.sv | 37 +++
 rtl/output_port_arbiter.sv | 88 ++++++++
 tb/tb_output_port_arbiter.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/noc_router_pkg.sv
`default_nettype none
//==============================================================================
// Module      : noc_router_pkg
// Description : Shared router constants, port indices, arbiter state encoding
//               and the mod-NUM_PORTS index helpers.
// Revision    : 1.0 - initial release
//==============================================================================
package noc_router_pkg;

   localparam int NUM_PORTS = 5;
   localparam int SEL_WIDTH = 3;

   localparam logic [SEL_WIDTH-1:0] SEL_IDLE = 3'b111;

   localparam logic [SEL_WIDTH-1:0] PORT_NORTH = 3'd0;
   localparam logic [SEL_WIDTH-1:0] PORT_EAST  = 3'd1;
   localparam logic [SEL_WIDTH-1:0] PORT_SOUTH = 3'd2;
   localparam logic [SEL_WIDTH-1:0] PORT_WEST  = 3'd3;
   localparam logic [SEL_WIDTH-1:0] PORT_LOCAL = 3'd4;

   typedef enum logic [0:0] {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arbState_t;

   // Port index + 1, wrapping at NUM_PORTS.
   function automatic logic [SEL_WIDTH-1:0] nextPort(input logic [SEL_WIDTH-1:0] p);
      return (p >= SEL_WIDTH'(NUM_PORTS - 1)) ? '0 : p + 1'b1;
   endfunction

   function automatic logic [NUM_PORTS-1:0] oneHot(input logic [SEL_WIDTH-1:0] idx);
      return NUM_PORTS'(1) << idx;
   endfunction

endpackage
`default_nettype wire

// File: rtl/output_port_arbiter_if.sv
`default_nettype none
//==============================================================================
// Module      : output_port_arbiter_if
// Description : Request/grant bundle between the input buffers, the output mux
//               and one output-port arbiter.
// Revision    : 1.0 - initial release
//==============================================================================
interface output_port_arbiter_if;
   import noc_router_pkg::*;

   logic [NUM_PORTS-1:0] Req;
   logic [NUM_PORTS-1:0] Tail;
   logic                 OutReady;
   logic [SEL_WIDTH-1:0] Sel;
   logic [NUM_PORTS-1:0] Grant;
   logic                 Transfer;

   modport master (
      output Req,
      output Tail,
      output OutReady,
      input  Sel,
      input  Grant,
      input  Transfer
   );

   modport slave (
      input  Req,
      input  Tail,
      input  OutReady,
      output Sel,
      output Grant,
      output Transfer
   );

endinterface
`default_nettype wire

// File: rtl/output_port_arbiter_rr_priority_picker.sv
`default_nettype none
//==============================================================================
// Module      : rr_priority_picker
// Description : Combinational round-robin search: first eligible request at or
//               after i_ptr, mod NUM_PORTS, ignoring bits set in i_exclude.
// Revision    : 1.0 - initial release
//==============================================================================
module rr_priority_picker
   import noc_router_pkg::*;
(
   input  wire logic [NUM_PORTS-1:0] i_req,
   input  wire logic [SEL_WIDTH-1:0] i_ptr,
   input  wire logic [NUM_PORTS-1:0] i_exclude,
   output logic                      o_found,
   output logic [SEL_WIDTH-1:0]      o_winner
);

   logic [NUM_PORTS-1:0] w_eligible;

   assign w_eligible = i_req & ~i_exclude;

   always_comb begin
      logic [SEL_WIDTH-1:0] idx;
      o_found  = 1'b0;
      o_winner = '0;
      idx      = i_ptr;
      for (int k = 0; k < NUM_PORTS; k++) begin
         if (!o_found && w_eligible[idx]) begin
            o_found  = 1'b1;
            o_winner = idx;
         end
         idx = nextPort(idx);
      end
   end

endmodule
`default_nettype wire

// File: rtl/output_port_arbiter.sv
`default_nettype none
//==============================================================================
// Module      : output_port_arbiter
// Description : Wormhole round-robin arbiter for one router output port; holds
//               the grant from head to tail flit and drives the mux select.
// Revision    : 1.0 - initial release
//==============================================================================
module output_port_arbiter
   import noc_router_pkg::*;
(
   input  wire logic             clk,
   input  wire logic             rst_n,
   output_port_arbiter_if.slave  bus
);

   arbState_t            r_state;
   logic [SEL_WIDTH-1:0] r_ptr;
   logic [SEL_WIDTH-1:0] r_sel;
   logic [NUM_PORTS-1:0] r_grant;

   logic                 w_busy;
   logic                 w_xfer;
   logic                 w_release;
   logic [SEL_WIDTH-1:0] w_pickPtr;
   logic [NUM_PORTS-1:0] w_exclude;
   logic                 w_found;
   logic [SEL_WIDTH-1:0] w_winner;

   assign w_busy    = (r_state == ARB_BUSY);
   assign w_xfer    = w_busy & (|(r_grant & bus.Req)) & bus.OutReady;
   assign w_release = w_xfer & (|(r_grant & bus.Tail));

   // On a tail the search restarts just past the releasing input and skips it,
   // so the next packet is granted without an idle cycle.
   assign w_pickPtr = w_release ? nextPort(r_sel) : r_ptr;
   assign w_exclude = w_release ? r_grant : '0;

   rr_priority_picker u_picker (
      .i_req     (bus.Req),
      .i_ptr     (w_pickPtr),
      .i_exclude (w_exclude),
      .o_found   (w_found),
      .o_winner  (w_winner)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ARB_IDLE;
         r_ptr   <= '0;
         r_grant <= '0;
         r_sel   <= SEL_IDLE;
      end else begin
         case (r_state)
            ARB_IDLE: begin
               if (w_found) begin
                  r_state <= ARB_BUSY;
                  r_grant <= oneHot(w_winner);
                  r_sel   <= w_winner;
               end
            end
            ARB_BUSY: begin
               if (w_release) begin
                  r_ptr <= w_pickPtr;
                  if (w_found) begin
                     r_grant <= oneHot(w_winner);
                     r_sel   <= w_winner;
                  end else begin
                     r_state <= ARB_IDLE;
                     r_grant <= '0;
                     r_sel   <= SEL_IDLE;
                  end
               end
            end
            default: begin
               r_state <= ARB_IDLE;
               r_grant <= '0;
               r_sel   <= SEL_IDLE;
            end
         endcase
      end
   end

   assign bus.Grant    = r_grant;
   assign bus.Sel      = r_sel;
   assign bus.Transfer = w_xfer;

endmodule
`default_nettype wire

// File: tb/tb_output_port_arbiter.sv
`default_nettype none
//==============================================================================
// Module      : tb_output_port_arbiter
// Description : Directed self-checking bench for output_port_arbiter.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_output_port_arbiter;

   typedef struct {
      logic [4:0] req;
      logic [4:0] tail;
      logic       rdy;
      logic       xfer;
      logic [4:0] grant;
      logic [2:0] sel;
   } vec_t;

   logic clk;
   logic rst_n;
   int   nChecks;
   int   nFails;

   output_port_arbiter_if bus ();

   output_port_arbiter dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   // Drive one cycle's inputs, check Transfer mid-cycle, then Grant/Sel after the edge.
   task automatic step(input string name, input logic [4:0] req, input logic [4:0] tail,
                       input logic rdy, input logic xfer, input logic [4:0] grant,
                       input logic [2:0] sel);
      bus.Req      = req;
      bus.Tail     = tail;
      bus.OutReady = rdy;
      @(negedge clk);
      chk({name, ".xfer"}, 8'(bus.Transfer), 8'(xfer));
      @(posedge clk);
      #1;
      chk({name, ".grant"}, 8'(bus.Grant), 8'(grant));
      chk({name, ".sel"}, 8'(bus.Sel), 8'(sel));
   endtask

   vec_t vecs [24];

   initial begin
      logic [7:0] rdyPat;
      logic [7:0] reqPat;
      int         sent;
      int         seen;
      logic [4:0] expGrant;

      nChecks = 0;
      nFails  = 0;

      vecs[0]  = '{5'b00000, 5'b00000, 1'b1, 1'b0, 5'b00000, 3'd7};
      // fairness: all request single-flit packets
      vecs[1]  = '{5'b11111, 5'b11111, 1'b1, 1'b0, 5'b00001, 3'd0};
      vecs[2]  = '{5'b11111, 5'b11111, 1'b1, 1'b1, 5'b00010, 3'd1};
      vecs[3]  = '{5'b11111, 5'b11111, 1'b1, 1'b1, 5'b00100, 3'd2};
      vecs[4]  = '{5'b11111, 5'b11111, 1'b1, 1'b1, 5'b01000, 3'd3};
      vecs[5]  = '{5'b11111, 5'b11111, 1'b1, 1'b1, 5'b10000, 3'd4};
      vecs[6]  = '{5'b11111, 5'b11111, 1'b1, 1'b1, 5'b00001, 3'd0};
      // release to idle, then late request from 4
      vecs[7]  = '{5'b00001, 5'b00001, 1'b1, 1'b1, 5'b00000, 3'd7};
      vecs[8]  = '{5'b10000, 5'b00000, 1'b1, 1'b0, 5'b10000, 3'd4};
      vecs[9]  = '{5'b10000, 5'b00000, 1'b0, 1'b0, 5'b10000, 3'd4};
      vecs[10] = '{5'b00001, 5'b00000, 1'b1, 1'b0, 5'b10000, 3'd4};
      vecs[11] = '{5'b10001, 5'b10000, 1'b1, 1'b1, 5'b00001, 3'd0};
      vecs[12] = '{5'b00001, 5'b00001, 1'b1, 1'b1, 5'b00000, 3'd7};
      // release with exclusion around input 3
      vecs[13] = '{5'b01000, 5'b00000, 1'b1, 1'b0, 5'b01000, 3'd3};
      vecs[14] = '{5'b11001, 5'b01000, 1'b1, 1'b1, 5'b10000, 3'd4};
      vecs[15] = '{5'b10001, 5'b10000, 1'b1, 1'b1, 5'b00001, 3'd0};
      vecs[16] = '{5'b01001, 5'b00001, 1'b1, 1'b1, 5'b01000, 3'd3};
      vecs[17] = '{5'b01001, 5'b01000, 1'b1, 1'b1, 5'b00001, 3'd0};
      vecs[18] = '{5'b00001, 5'b00001, 1'b1, 1'b1, 5'b00000, 3'd7};
      vecs[19] = '{5'b01000, 5'b01000, 1'b1, 1'b0, 5'b01000, 3'd3};
      vecs[20] = '{5'b01000, 5'b01000, 1'b1, 1'b1, 5'b00000, 3'd7};
      // wrap-around from ptr=4
      vecs[21] = '{5'b10001, 5'b00000, 1'b1, 1'b0, 5'b10000, 3'd4};
      vecs[22] = '{5'b10001, 5'b10000, 1'b1, 1'b1, 5'b00001, 3'd0};
      vecs[23] = '{5'b00000, 5'b00000, 1'b1, 1'b0, 5'b00001, 3'd0};

      rst_n        = 1'b0;
      bus.Req      = '0;
      bus.Tail     = '0;
      bus.OutReady = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset.grant", 8'(bus.Grant), 8'h00);
      chk("reset.sel", 8'(bus.Sel), 8'd7);
      chk("reset.xfer", 8'(bus.Transfer), 8'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 24; i++)
         step($sformatf("vec%0d", i), vecs[i].req, vecs[i].tail, vecs[i].rdy,
              vecs[i].xfer, vecs[i].grant, vecs[i].sel);

      // Wormhole hold: bring ptr to 2, then a 4-flit packet on input 2 with input 1 waiting.
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      step("wh.g1", 5'b00010, 5'b00010, 1'b1, 1'b0, 5'b00010, 3'd1);
      step("wh.rel1", 5'b00010, 5'b00010, 1'b1, 1'b1, 5'b00000, 3'd7);
      step("wh.g2", 5'b00110, 5'b00000, 1'b1, 1'b0, 5'b00100, 3'd2);

      rdyPat = 8'b11110001;
      reqPat = 8'b11101111;
      sent   = 0;
      seen   = 0;
      for (int c = 0; c < 8; c++) begin
         bus.Req      = {2'b00, reqPat[c], 2'b10};
         bus.Tail     = (sent == 3) ? 5'b00100 : 5'b00000;
         bus.OutReady = rdyPat[c];
         @(negedge clk);
         chk($sformatf("wh.c%0d.xfer", c), 8'(bus.Transfer), 8'(rdyPat[c] & reqPat[c]));
         if (bus.Transfer) seen++;
         if (rdyPat[c] & reqPat[c]) sent++;
         expGrant = (sent == 4) ? 5'b00010 : 5'b00100;
         @(posedge clk);
         #1;
         chk($sformatf("wh.c%0d.grant", c), 8'(bus.Grant), 8'(expGrant));
      end
      chk("wh.pulses", 8'(seen), 8'd4);

      // Hand back to input 2 and reset mid-packet.
      step("mr.g2", 5'b00110, 5'b00010, 1'b1, 1'b1, 5'b00100, 3'd2);
      step("mr.hold", 5'b00100, 5'b00000, 1'b0, 1'b0, 5'b00100, 3'd2);
      bus.OutReady = 1'b1;
      rst_n        = 1'b0;
      #1;
      chk("mr.grant", 8'(bus.Grant), 8'h00);
      chk("mr.sel", 8'(bus.Sel), 8'd7);
      chk("mr.xfer", 8'(bus.Transfer), 8'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      // ptr must be back at 0, so input 0 beats input 2.
      step("mr.after", 5'b00101, 5'b00000, 1'b0, 1'b0, 5'b00001, 3'd0);
      step("mr.hold0", 5'b00000, 5'b00000, 1'b1, 1'b0, 5'b00001, 3'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
`default_nettype wire
